// File: rtl/rpn_cpu_pkg.sv
// rpn_cpu_pkg: shared types and constants for the RPN stack calculator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rpn_cpu_pkg;

  localparam int DW = 8;

  // Sequencer state codes (also shown on Debug and in IP[7:4]).
  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_IDLE = 4'd1,
    ST_PUSH = 4'd2,
    ST_POP  = 4'd3,
    ST_ADD  = 4'd4,
    ST_MUL  = 4'd5
  } state_t;

  // Instruction-pointer base per state; the micro-step lands in the low nibble.
  localparam logic [7:0] IP_INIT = 8'h00;
  localparam logic [7:0] IP_IDLE = 8'h10;
  localparam logic [7:0] IP_PUSH = 8'h20;
  localparam logic [7:0] IP_POP  = 8'h30;
  localparam logic [7:0] IP_ADD  = 8'h40;
  localparam logic [7:0] IP_MUL  = 8'h50;

  // Commands latched from the button edges.
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_PUSH = 3'd1,
    CMD_POP  = 3'd2,
    CMD_ADD  = 3'd3,
    CMD_MUL  = 3'd4
  } cmd_t;

  function automatic logic [7:0] ip_base(state_t s);
    case (s)
      ST_INIT: return IP_INIT;
      ST_IDLE: return IP_IDLE;
      ST_PUSH: return IP_PUSH;
      ST_POP:  return IP_POP;
      ST_ADD:  return IP_ADD;
      ST_MUL:  return IP_MUL;
      default: return IP_INIT;
    endcase
  endfunction

endpackage

// File: rtl/rpn_btn_sync.sv
// rpn_btn_sync: 2-FF synchroniser for an asynchronous button plus rising-edge pulse.
// Latency: pulse is high for one clock, 2 clocks after the input is first sampled high.
// Backpressure: none; a held level produces a single pulse.
module rpn_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  // Two synchroniser stages plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/rpn_cpu.sv
// rpn_cpu: 8-bit signed RPN stack calculator sequenced by push-button commands (RPN_CPU_SAT_EN: saturating ADD/MULT).
// Latency: Turbo=1 -> Dout updates within 6 clocks of a button edge; Turbo=0 -> one micro-step per 2^SLOW_DIV clocks.
// Backpressure: one command is held while IDLE; edges arriving outside IDLE or with a command pending are dropped.
module rpn_cpu
  import rpn_cpu_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SLOW_DIV = 24
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [DW-1:0] Din,
  input  logic          Sample,
  input  logic [2:0]    Btns,
  input  logic          Turbo,
  output logic [DW-1:0] Dout,
  output logic          Dval,
  output logic [5:0]    GPO,
  output logic [3:0]    Debug,
  output logic [7:0]    IP
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] SP_FULL    = 4'(DEPTH);
  localparam logic [3:0] LAST_ENTRY = 4'(DEPTH - 1);

  logic          smp_p;
  logic [2:0]    btn_p;
  logic [SLOW_DIV-1:0] div_q;
  logic          step_en;
  cmd_t          cap_cmd, cmd_q;
  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic          do_clr, do_push, do_pop, do_read, do_write, do_err;
  logic [3:0]    sp_q;
  logic [DW-1:0] stk [DEPTH];
  logic [DW-1:0] opa_q, opb_q, dout_q, res8;
  logic          dval_q, ovf_q, err_q, ovf_c;
  logic [15:0]   ea, eb, full;
  logic [AW-1:0] idx_sp, idx_top, idx_nxt, idx_clr;

  rpn_btn_sync u_sync_smp (.clk(clk), .rst_n(Reset), .din(Sample), .pulse(smp_p));

  for (genvar i = 0; i < 3; i++) begin : g_btn
    rpn_btn_sync u_sync (.clk(clk), .rst_n(Reset), .din(Btns[i]), .pulse(btn_p[i]));
  end

  // Free-running divider; its all-ones count is the slow step tick.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) div_q <= '0;
    else        div_q <= div_q + SLOW_DIV'(1);
  end

  assign step_en = Turbo | (&div_q);

  // Priority encode simultaneous edges: Sample > POP > ADD > MULT.
  always_comb begin
    cap_cmd = CMD_NONE;
    if (smp_p)         cap_cmd = CMD_PUSH;
    else if (btn_p[2]) cap_cmd = CMD_POP;
    else if (btn_p[1]) cap_cmd = CMD_ADD;
    else if (btn_p[0]) cap_cmd = CMD_MUL;
  end

  // One-entry command register: filled only in IDLE, emptied when IDLE steps into the command.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cmd_q <= CMD_NONE;
    end else if (state_q == ST_IDLE) begin
      if (cmd_q != CMD_NONE) begin
        if (step_en) cmd_q <= CMD_NONE;
      end else begin
        cmd_q <= cap_cmd;
      end
    end
  end

  // Sequencer state and micro-step registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next state and micro-step strobes; nothing moves without a step enable.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    do_clr   = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_read  = 1'b0;
    do_write = 1'b0;
    do_err   = 1'b0;
    if (step_en) begin
      case (state_q)
        ST_INIT: begin
          do_clr = 1'b1;
          if (step_q == LAST_ENTRY) begin
            state_d = ST_IDLE;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        ST_IDLE: begin
          step_d = 4'd0;
          case (cmd_q)
            CMD_PUSH: state_d = ST_PUSH;
            CMD_POP:  state_d = ST_POP;
            CMD_ADD:  state_d = ST_ADD;
            CMD_MUL:  state_d = ST_MUL;
            default:  state_d = ST_IDLE;
          endcase
        end
        ST_PUSH: begin
          if (sp_q == SP_FULL) do_err  = 1'b1;
          else                 do_push = 1'b1;
          state_d = ST_IDLE;
          step_d  = 4'd0;
        end
        ST_POP: begin
          if (sp_q == 4'd0) do_err = 1'b1;
          else              do_pop = 1'b1;
          state_d = ST_IDLE;
          step_d  = 4'd0;
        end
        ST_ADD, ST_MUL: begin
          if (step_q == 4'd0) begin
            if (sp_q < 4'd2) begin
              do_err  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              do_read = 1'b1;
              step_d  = 4'd1;
            end
          end else begin
            do_write = 1'b1;
            state_d  = ST_IDLE;
            step_d   = 4'd0;
          end
        end
        default: begin
          state_d = ST_INIT;
          step_d  = 4'd0;
        end
      endcase
    end
  end

  assign idx_sp  = AW'(sp_q);
  assign idx_top = AW'(sp_q - 4'd1);
  assign idx_nxt = AW'(sp_q - 4'd2);
  assign idx_clr = AW'(step_q);

  // ALU: full-precision sum/product of the two latched operands, then wrap or saturate.
  always_comb begin
    ea    = {{8{opa_q[7]}}, opa_q};
    eb    = {{8{opb_q[7]}}, opb_q};
    full  = (state_q == ST_MUL) ? ea * eb : ea + eb;
    ovf_c = (full[15:7] != {9{full[7]}});
`ifdef RPN_CPU_SAT_EN
    res8  = ovf_c ? (full[15] ? 8'h80 : 8'h7f) : full[7:0];
`else
    res8  = full[7:0];
`endif
  end

  // Stack RAM writes: INIT clear, PUSH, and arithmetic result over operand a.
  always_ff @(posedge clk) begin
    if (do_clr)        stk[idx_clr] <= '0;
    else if (do_push)  stk[idx_sp]  <= Din;
    else if (do_write) stk[idx_nxt] <= res8;
  end

  // Stack pointer, operand latches, registered top-of-stack and flags.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sp_q   <= 4'd0;
      opa_q  <= '0;
      opb_q  <= '0;
      dout_q <= '0;
      dval_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (do_push) begin
        sp_q   <= sp_q + 4'd1;
        dout_q <= Din;
        dval_q <= 1'b1;
        err_q  <= 1'b0;
      end
      if (do_pop) begin
        sp_q   <= sp_q - 4'd1;
        dout_q <= (sp_q >= 4'd2) ? stk[idx_nxt] : '0;
        dval_q <= (sp_q >= 4'd2);
        err_q  <= 1'b0;
      end
      if (do_read) begin
        opa_q <= stk[idx_nxt];
        opb_q <= stk[idx_top];
      end
      if (do_write) begin
        sp_q   <= sp_q - 4'd1;
        dout_q <= res8;
        dval_q <= 1'b1;
        ovf_q  <= ovf_c;
        err_q  <= 1'b0;
      end
      if (do_err) err_q <= 1'b1;
    end
  end

  assign Dout  = dout_q;
  assign Dval  = dval_q;
  assign GPO   = {err_q, ovf_q, sp_q};
  assign Debug = state_q;
  assign IP    = ip_base(state_q) | {4'h0, step_q};

endmodule

// File: tb/tb_rpn_cpu.sv
// tb_rpn_cpu: randomized and directed button sequences checked against a queue-based stack model.
// Latency: waits a fixed budget per command (Turbo=1: 14 clocks, Turbo=0: 90 clocks).
// Backpressure: one command at a time; outputs compared only while the model is settled.
module tb_rpn_cpu;

  localparam int DEPTH    = 8;
  localparam int SLOW_DIV = 4;

  logic       clk    = 1'b0;
  logic       Reset  = 1'b0;
  logic [7:0] Din    = 8'd0;
  logic       Sample = 1'b0;
  logic [2:0] Btns   = 3'd0;
  logic       Turbo  = 1'b1;
  logic [7:0] Dout;
  logic       Dval;
  logic [5:0] GPO;
  logic [3:0] Debug;
  logic [7:0] IP;

  rpn_cpu #(.DEPTH(DEPTH), .SLOW_DIV(SLOW_DIV)) dut (
    .clk(clk), .Reset(Reset), .Din(Din), .Sample(Sample), .Btns(Btns),
    .Turbo(Turbo), .Dout(Dout), .Dval(Dval), .GPO(GPO), .Debug(Debug), .IP(IP)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit settled = 1'b0;

  // Behavioural model: the stack as a queue of signed ints plus two flags.
  int mstk[$];
  bit merr = 1'b0;
  bit movf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int to_s8(input int v);
    int r;
    r = v & 255;
    if (r > 127) r -= 256;
    return r;
  endfunction

  function automatic int exp_dout();
    if (mstk.size() == 0) return 0;
    return mstk[mstk.size() - 1];
  endfunction

  // cmd: 0=PUSH 1=POP 2=ADD 3=MULT
  task automatic m_exec(input int cmd, input int v);
    int a, b, full, r;
    case (cmd)
      0: begin
        if (mstk.size() == DEPTH) merr = 1'b1;
        else begin mstk.push_back(to_s8(v)); merr = 1'b0; end
      end
      1: begin
        if (mstk.size() == 0) merr = 1'b1;
        else begin void'(mstk.pop_back()); merr = 1'b0; end
      end
      default: begin
        if (mstk.size() < 2) merr = 1'b1;
        else begin
          b = mstk.pop_back();
          a = mstk.pop_back();
          full = (cmd == 2) ? a + b : a * b;
          movf = (full > 127) || (full < -128);
`ifdef RPN_CPU_SAT_EN
          r = (full > 127) ? 127 : ((full < -128) ? -128 : full);
`else
          r = to_s8(full);
`endif
          mstk.push_back(r);
          merr = 1'b0;
        end
      end
    endcase
  endtask

  // Compare process: every settled cycle, mid-way between active edges.
  always @(posedge clk) begin
    #5;
    if (settled) begin
      chk("dout",  int'($signed(Dout)), exp_dout());
      chk("dval",  int'(Dval), (mstk.size() != 0) ? 1 : 0);
      chk("depth", int'(GPO[3:0]), mstk.size());
      chk("ovf",   int'(GPO[4]), int'(movf));
      chk("err",   int'(GPO[5]), int'(merr));
      chk("ip",    int'(IP), 'h10);
      chk("debug", int'(Debug), 1);
    end
  end

  task automatic press(input int cmd, input int v);
    settled = 1'b0;
    @(negedge clk);
    Din = v[7:0];
    case (cmd)
      0:       Sample  = 1'b1;
      1:       Btns[2] = 1'b1;
      2:       Btns[1] = 1'b1;
      default: Btns[0] = 1'b1;
    endcase
    #25;
    Sample = 1'b0;
    Btns   = 3'b000;
    repeat (Turbo ? 14 : 90) @(negedge clk);
    m_exec(cmd, v);
    settled = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic model_clear();
    mstk.delete();
    merr = 1'b0;
    movf = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, v, prev, nchg, t0, t1, v1, v2;

    // Reset state while held.
    repeat (3) @(negedge clk);
    chk("rst_ip",    int'(IP), 0);
    chk("rst_debug", int'(Debug), 0);
    chk("rst_dout",  int'(Dout), 0);
    chk("rst_dval",  int'(Dval), 0);
    chk("rst_gpo",   int'(GPO), 0);
    Reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("init_ip",    int'(IP), 'h10);
    chk("init_debug", int'(Debug), 1);
    chk("init_gpo",   int'(GPO), 0);
    model_clear();
    settled = 1'b1;
    repeat (2) @(negedge clk);

    // Directed arithmetic.
    press(0, 2); press(0, 5); press(2, 0);
    chk("lit_add_dout", int'($signed(Dout)), 7);
    chk("lit_add_gpo",  int'(GPO), 1);
    press(0, -3); press(3, 0);
    chk("lit_mul_dout", int'($signed(Dout)), -21);
    press(1, 0);
    chk("lit_pop_dval", int'(Dval), 0);
    chk("lit_pop_dout", int'(Dout), 0);
    press(1, 0);
    chk("lit_pop_err", int'(GPO), 'h20);

    // Push 1..6 then MULT five times.
    for (int i = 1; i <= 6; i++) press(0, i);
    for (int i = 0; i < 5; i++) press(3, 0);
`ifdef RPN_CPU_SAT_EN
    chk("lit_chain_dout", int'($signed(Dout)), 127);
`else
    chk("lit_chain_dout", int'($signed(Dout)), -48);
`endif
    chk("lit_chain_gpo", int'(GPO), 1);

    // Overfill, then ADD with depth 1.
    press(1, 0);
    for (int i = 11; i <= 19; i++) press(0, i);
    chk("lit_full_dout", int'(Dout), 18);
    chk("lit_full_gpo",  int'(GPO[5]), 1);
    chk("lit_full_dep",  int'(GPO[3:0]), 8);
    for (int i = 0; i < 7; i++) press(1, 0);
    press(2, 0);
    chk("lit_add1_dout", int'(Dout), 11);
    chk("lit_add1_err",  int'(GPO[5]), 1);
    chk("lit_add1_dep",  int'(GPO[3:0]), 1);

    // Randomized command stream.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      v = $urandom_range(0, 255);
      if (r < 4)      press(0, v);
      else if (r < 6) press(1, 0);
      else if (r < 8) press(2, 0);
      else            press(3, 0);
    end

    // Reset in the middle of a command aborts immediately.
    press(0, 40); press(0, 41);
    settled = 1'b0;
    @(negedge clk);
    Btns[1] = 1'b1;
    #25;
    Btns = 3'b000;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    #1;
    chk("mid_ip",    int'(IP), 0);
    chk("mid_debug", int'(Debug), 0);
    chk("mid_gpo",   int'(GPO), 0);
    chk("mid_dval",  int'(Dval), 0);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    model_clear();
    repeat (50) @(negedge clk);
    settled = 1'b1;
    repeat (3) @(negedge clk);

    // Slow stepping with simultaneous Sample and ADD: only PUSH runs, IP moves every 16 clocks.
    settled = 1'b0;
    Turbo = 1'b0;
    repeat (5) @(negedge clk);
    Din = 8'd33;
    Sample = 1'b1;
    Btns[1] = 1'b1;
    #25;
    Sample = 1'b0;
    Btns = 3'b000;
    prev = IP; nchg = 0; t0 = 0; t1 = 0; v1 = 0; v2 = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk);
      #5;
      if (int'(IP) != prev) begin
        nchg++;
        if (nchg == 1) begin t0 = c; v1 = IP; end
        else if (nchg == 2) begin t1 = c; v2 = IP; end
        prev = IP;
      end
    end
    chk("slow_nchg",     nchg, 2);
    chk("slow_ip1",      v1, 'h20);
    chk("slow_ip2",      v2, 'h10);
    chk("slow_interval", t1 - t0, 16);
    @(negedge clk);
    m_exec(0, 33);
    settled = 1'b1;
    repeat (3) @(negedge clk);
    chk("slow_dout", int'(Dout), 33);
    press(0, 44);
    chk("slow_push2", int'(Dout), 44);
    settled = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
